// File: rtl/serial_word_unloader.sv
// serial_word_unloader: accepts a WIDTH-bit word over valid/ready and streams it out LSB first.
// Defining SERIAL_WORD_UNLOADER_PARITY_EN appends one even-parity beat after the data beats.
module serial_word_unloader #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy
);

`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
    localparam int NBEATS = WIDTH + 1;
`else
    localparam int NBEATS = WIDTH;
`endif
    localparam int CW = $clog2(NBEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             shifting_s;
    logic             last_s;
    logic             beat_s;
    logic             load_xfer_s;

`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
    logic             par_r, par_s;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign shifting_s  = (state_r == SHIFT);
    assign last_s      = shifting_s & (cnt_r == LAST_CNT);
    assign beat_s      = shifting_s & ser_ready;
    // Ready either when idle or on the closing beat, so a new word can follow with no gap.
    assign load_ready  = ~shifting_s | (beat_s & last_s);
    assign load_xfer_s = load_valid & load_ready;

    assign ser_valid = shifting_s;
    assign busy      = shifting_s;
    assign ser_last  = last_s;
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
    assign ser_bit   = shifting_s & (last_s ? par_r : shift_r[0]);
`else
    assign ser_bit   = shifting_s & shift_r[0];
`endif

    // Next-state logic for the IDLE/SHIFT sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_xfer_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (beat_s && last_s) begin
                    state_s = load_valid ? SHIFT : IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath next values: capture on load, shift on a non-final beat, hold on stall.
    always_comb begin
        shift_s = shift_r;
        cnt_s   = cnt_r;
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
        par_s   = par_r;
`endif
        if (load_xfer_s) begin
            shift_s = load_data;
            cnt_s   = {CW{1'b0}};
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
            par_s   = even_parity(load_data);
`endif
        end else if (beat_s) begin
            if (last_s) begin
                cnt_s = {CW{1'b0}};
            end else begin
                shift_s = {1'b0, shift_r[WIDTH-1:1]};
                cnt_s   = cnt_r + CW'(1);
            end
        end else begin
            shift_s = shift_r;
            cnt_s   = cnt_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_unloader.sv
// Bench for serial_word_unloader: a bit-queue reference model checked every cycle,
// plus directed scenarios with hand-computed bit sequences.
module tb_serial_word_unloader;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = 5'b00000;
    logic         load_ready;
    logic         ser_ready = 1'b1;
    logic         ser_valid;
    logic         ser_bit;
    logic         ser_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Reference model: bits still owed downstream, oldest first.
    logic q[$];

    logic seq1 [0:4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic seq4 [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic seq5 [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic seq6 [0:5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    serial_word_unloader #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_ready  (ser_ready),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Model update: one bit leaves on each accepted beat, a whole word enters on each load.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic bit lr = (q.size() == 0) || (ser_ready && q.size() == 1);
            if (q.size() > 0 && ser_ready) q.delete(0);
            if (load_valid && lr) begin
                for (int i = 0; i < W; i++) q.push_back(load_data[i]);
`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
                q.push_back(^load_data);
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("m_load_ready", load_ready, (q.size() == 0) || (ser_ready && q.size() == 1));
        chk("m_ser_valid", ser_valid, q.size() != 0);
        chk("m_busy", busy, q.size() != 0);
        chk("m_ser_bit", ser_bit, (q.size() != 0) ? q[0] : 1'b0);
        chk("m_ser_last", ser_last, q.size() == 1);
    end

    initial begin
        tick();
        settle();
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ser_bit", ser_bit, 1'b0);
        chk("rst_ser_last", ser_last, 1'b0);
        tick();
        rst = 1'b0;

`ifdef SERIAL_WORD_UNLOADER_PARITY_EN
        load_valid = 1'b1; load_data = 5'b10110;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t6_bit", ser_bit, seq6[i]);
            chk("t6_last", ser_last, i == 5);
            tick();
        end
        settle();
        chk("t6_busy_end", busy, 1'b0);
`else
        // Plain word at full rate.
        load_valid = 1'b1; load_data = 5'b10110;
        settle();
        chk("t1_idle_ready", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t1_bit", ser_bit, seq1[i]);
            chk("t1_last", ser_last, i == 4);
            tick();
        end
        settle();
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_ready_end", load_ready, 1'b1);

        // Stall after the first beat.
        tick();
        load_valid = 1'b1; load_data = 5'b00011;
        tick();
        load_valid = 1'b0;
        settle();
        chk("t2_bit1", ser_bit, 1'b1);
        tick();
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_stall_bit", ser_bit, 1'b1);
            chk("t2_stall_valid", ser_valid, 1'b1);
            chk("t2_stall_last", ser_last, 1'b0);
            tick();
        end
        ser_ready = 1'b1;
        settle();
        chk("t2_bit2", ser_bit, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_tail_bit", ser_bit, 1'b0);
            chk("t2_tail_last", ser_last, i == 2);
            tick();
        end
        settle();
        chk("t2_busy_end", busy, 1'b0);

        // Back-to-back words with load_valid held high.
        tick();
        load_valid = 1'b1; load_data = 5'b11111;
        tick();
        load_data = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_a_bit", ser_bit, 1'b1);
            chk("t3_a_ready", load_ready, i == 4);
            tick();
        end
        load_valid = 1'b0;
        settle();
        chk("t3_b_bit0", ser_bit, 1'b1);
        chk("t3_b_valid", ser_valid, 1'b1);
        chk("t3_b_last0", ser_last, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("t3_b_bit", ser_bit, 1'b0);
        end
        tick();
        settle();
        chk("t3_busy_end", busy, 1'b0);

        // Load offered mid-word is ignored.
        tick();
        load_valid = 1'b1; load_data = 5'b11001;
        tick();
        for (int i = 0; i < 5; i++) begin
            load_valid = (i == 1);
            load_data  = (i == 1) ? 5'b01010 : 5'b11001;
            settle();
            chk("t4_bit", ser_bit, seq4[i]);
            if (i == 1) chk("t4_ready_mid", load_ready, 1'b0);
            tick();
        end
        load_valid = 1'b0;
        settle();
        chk("t4_busy_end", busy, 1'b0);

        // Reset in the middle of a word.
        tick();
        load_valid = 1'b1; load_data = 5'b10011;
        tick();
        load_valid = 1'b0;
        settle();
        tick();
        settle();
        tick();
        rst = 1'b1;
        settle();
        chk("t5_rst_valid", ser_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", load_ready, 1'b1);
        tick();
        rst = 1'b0;
        load_valid = 1'b1; load_data = 5'b00101;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_bit", ser_bit, seq5[i]);
            tick();
        end
        settle();
        chk("t5_busy_end", busy, 1'b0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
